uart_alu_cmd_master: RTL and testbench

Host-side initiator for the UART ALU command protocol. On a start pulse it latches two 16-bit operands and a 2-bit operation, then serialises them as a 5-byte command through a uart_basic transmitter. It then collects the 2-byte 16-bit result returned by the remote ALU responder and presents it with a done pulse. It is used for board-to-board links and for loopback self-test against the ALU command receiver.

---
 rtl/uart_alu_cmd_master.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_alu_cmd_master.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_cmd_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : uart_alu_cmd_master
// Brief    : Sends a 5-byte ALU command over uart_basic and collects the 2-byte
//            result. Macro CMD_TIMEOUT_EN adds a response timeout.
// Revision : 1.0
// ---------------------------------------------------------------------------
module uart_alu_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 10000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic [1:0]  operacion,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_RX_LO   = 3'd4,
    S_RX_HI   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'd4;

  state_t      state_q, state_d;
  logic [15:0] op_a_q, op_a_d;
  logic [15:0] op_b_q, op_b_d;
  logic [1:0]  opc_q, opc_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] result_q, result_d;
  logic [7:0]  low_q, low_d;
  logic [7:0]  cmd_byte;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
`endif

  always_comb begin
    case (idx_q)
      3'd0:    cmd_byte = op_a_q[7:0];
      3'd1:    cmd_byte = op_a_q[15:8];
      3'd2:    cmd_byte = op_b_q[7:0];
      3'd3:    cmd_byte = op_b_q[15:8];
      default: cmd_byte = {6'b0, opc_q};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    opc_d      = opc_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    low_d      = low_q;
`ifdef CMD_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_a_d  = op_a;
          op_b_d  = op_b;
          opc_d   = operacion;
          idx_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = S_SEND;
        end
      end

      // tx_data only moves together with the start pulse, so it is stable
      // for the whole time the transmitter reports busy.
      S_SEND: begin
        if (!tx_busy) begin
          tx_data_d  = cmd_byte;
          tx_start_d = 1'b1;
          state_d    = S_WAIT_HI;
        end
      end

      S_WAIT_HI: begin
        if (tx_busy) begin
          state_d = S_WAIT_LO;
        end
      end

      S_WAIT_LO: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_RX_LO;
`ifdef CMD_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_SEND;
          end
        end
      end

      S_RX_LO: begin
        if (rx_ready) begin
          low_d   = rx_data;
          state_d = S_RX_HI;
`ifdef CMD_TIMEOUT_EN
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          timeout_err_d = 1'b1;
          busy_d        = 1'b0;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end

      S_RX_HI: begin
        if (rx_ready) begin
          result_d = {rx_data, low_q};
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_DONE;
`ifdef CMD_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          timeout_err_d = 1'b1;
          busy_d        = 1'b0;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      opc_q      <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      low_q      <= '0;
`ifdef CMD_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      opc_q      <= opc_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      low_q      <= low_d;
`ifdef CMD_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;

`ifdef CMD_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  // TIMEOUT_CYCLES has no effect when the timeout feature is compiled out.
  assign timeout_err = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_cmd_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_uart_alu_cmd_master
// Brief    : Self-checking bench with a behavioural uart_basic stand-in and a
//            byte-level reference model of the command/response protocol.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_uart_alu_cmd_master;

  localparam int unsigned TO_CYCLES = 100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic [1:0]  operacion = '0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  // transmitter model state
  logic [7:0] sent_q[$];
  logic [7:0] last_tx = '0;
  int  busy_left = 0;
  bit  hold_busy = 1'b0;
  int  start_while_busy = 0;
  int  unstable = 0;
  int  done_cnt = 0;
  int  timeout_cnt = 0;

  uart_alu_cmd_master #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op_a        (op_a),
    .op_b        (op_b),
    .operacion   (operacion),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .timeout_err (timeout_err)
  );

  initial forever #5 clock = ~clock;

  // uart_basic stand-in: captures each started byte and stays busy for a
  // random frame length; hold_busy forces it busy while idle.
  always @(negedge clock) begin
    if (reset) begin
      tx_busy   = 1'b0;
      busy_left = 0;
    end else begin
      if (tx_start) begin
        if (tx_busy) start_while_busy++;
        sent_q.push_back(tx_data);
        last_tx   = tx_data;
        busy_left = $urandom_range(3, 12);
        tx_busy   = 1'b1;
      end else if (busy_left > 0) begin
        if (tx_data !== last_tx) unstable++;
        busy_left--;
        if (busy_left == 0) tx_busy = hold_busy;
      end else begin
        tx_busy = hold_busy;
      end
      done_cnt    += int'(done);
      timeout_cnt += int'(timeout_err);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=simulation still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "/tx_data"},     32'(tx_data),     32'h0);
    check({tag, "/tx_start"},    32'(tx_start),    32'h0);
    check({tag, "/busy"},        32'(busy),        32'h0);
    check({tag, "/done"},        32'(done),        32'h0);
    check({tag, "/result"},      32'(result),      32'h0);
    check({tag, "/timeout_err"}, 32'(timeout_err), 32'h0);
  endtask

  // Issue a command and wait until all 5 bytes have left the transmitter.
  task automatic send_command(input logic [15:0] a, input logic [15:0] b,
                              input logic [1:0] op, input int hold_cycles,
                              input bit disturb, input string tag);
    logic [7:0] exp_bytes[5];
    int cyc;
    exp_bytes = '{a[7:0], a[15:8], b[7:0], b[15:8], {6'b0, op}};
    sent_q.delete();
    start_while_busy = 0;
    unstable = 0;
    if (hold_cycles > 0) begin
      hold_busy = 1'b1;
      step();
    end
    op_a = a; op_b = b; operacion = op; start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "/busy_up"}, 32'(busy), 32'h1);
    if (hold_cycles > 0) begin
      for (int h = 0; h < hold_cycles; h++) step();
      check({tag, "/no_tx_while_held"}, 32'(sent_q.size()), 32'h0);
      hold_busy = 1'b0;
    end
    cyc = 0;
    while (!(sent_q.size() == 5 && !tx_busy) && cyc < 3000) begin
      step();
      cyc++;
      if (disturb && cyc == 3) begin start = 1'b1; op_a = ~a; op_b = ~b; end
      if (disturb && cyc == 4) start = 1'b0;
      if (disturb && cyc == 6) begin rx_data = 8'hEE; rx_ready = 1'b1; end
      if (disturb && cyc == 7) rx_ready = 1'b0;
    end
    check({tag, "/tx_complete_in_time"}, 32'(cyc < 3000), 32'h1);
    step();
    step();
    check({tag, "/byte_count"}, 32'(sent_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s/byte%0d", tag, i),
            (i < sent_q.size()) ? 32'(sent_q[i]) : 32'hFFFF_FFFF, 32'(exp_bytes[i]));
    check({tag, "/no_start_while_busy"}, 32'(start_while_busy), 32'h0);
    check({tag, "/tx_data_stable"}, 32'(unstable), 32'h0);
    check({tag, "/busy_in_rx"}, 32'(busy), 32'h1);
  endtask

  task automatic respond(input logic [7:0] lo, input logic [7:0] hi,
                         input bit disturb, input bit start_at_done, input string tag);
    int dc;
    dc = done_cnt;
    if (disturb) begin
      start = 1'b1; step(); start = 1'b0; step();
    end
    rx_data = lo; rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    if (disturb) begin
      start = 1'b1; step(); start = 1'b0; step();
    end
    rx_data = hi; rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    check({tag, "/done_pulse"}, 32'(done), 32'h1);
    check({tag, "/busy_falls_with_done"}, 32'(busy), 32'h0);
    check({tag, "/result"}, 32'(result), 32'({hi, lo}));
    if (start_at_done) start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "/done_one_cycle"}, 32'(done), 32'h0);
    step();
    check({tag, "/idle_after_done"}, 32'(busy), 32'h0);
    step();
    check({tag, "/done_count"}, 32'(done_cnt - dc), 32'd1);
    check({tag, "/no_extra_tx"}, 32'(sent_q.size()), 32'd5);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [1:0]  rop;
    logic [7:0]  rlo, rhi;
    logic [15:0] prev_result;
    int n, dc;

    // reset state
    step();
    check_idle_outputs("reset");
    step();
    reset = 1'b0;
    step();
    check_idle_outputs("post_reset");

    // directed command from the reference example
    send_command(16'h1234, 16'h00FF, 2'b01, 0, 1'b0, "basic");
    respond(8'hCD, 8'hAB, 1'b0, 1'b0, "basic");

    // stray starts and stray rx byte while busy
    send_command(16'hBEEF, 16'h0F0F, 2'b10, 0, 1'b1, "disturb");
    respond(8'h11, 8'h22, 1'b1, 1'b0, "disturb");

    // transmitter busy before the first byte
    send_command(16'h8001, 16'h7FFE, 2'b11, 50, 1'b0, "held");
    respond(8'h00, 8'hFF, 1'b0, 1'b1, "held");

    // randomized commands against the protocol model
    for (int t = 0; t < 4; t++) begin
      ra = 16'($urandom); rb = 16'($urandom); rop = 2'($urandom);
      rlo = 8'($urandom); rhi = 8'($urandom);
      send_command(ra, rb, rop, 0, 1'b0, $sformatf("rand%0d", t));
      respond(rlo, rhi, 1'b0, (t == 1), $sformatf("rand%0d", t));
    end

    // reset while waiting for byte 2 to finish
    sent_q.delete();
    op_a = 16'hA5C3; op_b = 16'h3C5A; operacion = 2'b10; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (sent_q.size() < 3 && n < 1000) begin step(); n++; end
    check("midreset/reached_byte2", 32'(sent_q.size()), 32'd3);
    step();
    reset = 1'b1;
    #1;
    check_idle_outputs("midreset");
    step();
    step();
    reset = 1'b0;
    step();
    send_command(16'h4321, 16'h8765, 2'b00, 0, 1'b0, "after_reset");
    respond(8'h9A, 8'h78, 1'b0, 1'b0, "after_reset");

`ifdef CMD_TIMEOUT_EN
    send_command(16'hC0DE, 16'hF00D, 2'b01, 0, 1'b0, "timeout");
    prev_result = result;
    dc = done_cnt;
    rx_data = 8'h5A; rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    n = 0;
    while (!timeout_err && n < 500) begin step(); n++; end
    check("timeout/latency", 32'(n), 32'(TO_CYCLES));
    check("timeout/busy_dropped", 32'(busy), 32'h0);
    check("timeout/result_kept", 32'(result), 32'(prev_result));
    step();
    check("timeout/one_cycle", 32'(timeout_err), 32'h0);
    check("timeout/no_done", 32'(done_cnt - dc), 32'h0);
    check("timeout/pulse_count", 32'(timeout_cnt), 32'h1);
    send_command(16'h0102, 16'h0304, 2'b11, 0, 1'b0, "after_timeout");
    respond(8'h55, 8'hAA, 1'b0, 1'b0, "after_timeout");
`else
    check("no_timeout_feature/timeout_err_never", 32'(timeout_cnt), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
